// File: rtl/sseg_scan_decoder.sv
// Receive-side decoder for a multiplexed four-digit seven-segment bus.
// Qualifies each digit after a stable dwell, decodes it to BCD and publishes whole frames.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sseg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        frame_err,
  output logic        frame_valid
);

  typedef enum logic {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;

  localparam logic [15:0] CNT_MAX  = 16'(STABLE_CYCLES);
  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  // Returns {invalid, value}; the dp bit is already stripped by the caller.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b1_1111;
    case (seg)
      7'h7E: res = 5'h00;
      7'h30: res = 5'h01;
      7'h6D: res = 5'h02;
      7'h79: res = 5'h03;
      7'h33: res = 5'h04;
      7'h5B: res = 5'h05;
      7'h5F: res = 5'h06;
      7'h70: res = 5'h07;
      7'h7F: res = 5'h08;
      7'h7B: res = 5'h09;
      default: res = 5'b1_1111;
    endcase
    return res;
  endfunction

  // Returns {exactly_one_selected, digit_index} for an active-low anode vector.
  function automatic logic [2:0] anode_sel(input logic [3:0] an);
    logic [2:0] res;
    res = 3'b000;
    case (an)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  logic [3:0]  an_q, an_p1;
  logic [7:0]  sseg_q, sseg_p1;
  logic [15:0] stable_cnt;
  logic        same, cap_stb, cap_ok, cap_acc, cap_err;
  logic [1:0]  cap_idx;
  logic [3:0]  cap_val;
  logic [15:0] shadow_val;
  logic [3:0]  shadow_dp, shadow_err;
  logic [3:0]  seen, seen_nxt;
  state_t      state, state_nxt;

  // Stage p0: input registers and their one-cycle-old copy for the stability compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q       <= 4'hF;
      sseg_q     <= 8'h00;
      an_p1      <= 4'hF;
      sseg_p1    <= 8'h00;
      stable_cnt <= 16'd0;
    end else begin
      an_q    <= an_in;
      sseg_q  <= sseg_in;
      an_p1   <= an_q;
      sseg_p1 <= sseg_q;
      if (!same)
        stable_cnt <= 16'd0;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + 16'd1;
    end
  end

  assign same    = (an_q == an_p1) && (sseg_q == sseg_p1);
  assign cap_stb = same && (stable_cnt == CNT_LAST);
  assign {cap_ok, cap_idx}  = anode_sel(an_q);
  assign cap_acc = cap_stb && cap_ok;
  assign {cap_err, cap_val} = seg_decode(sseg_q[7:1]);

  // Stage p1: per-digit shadow frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      shadow_err <= 4'h0;
    end else if (cap_acc) begin
      shadow_val[{cap_idx, 2'b00} +: 4] <= cap_val;
      shadow_dp[cap_idx]                <= sseg_q[0];
      shadow_err[cap_idx]               <= cap_err;
    end
  end

  // A capture landing in the PUBLISH cycle starts the next frame's seen set.
  always_comb begin
    seen_nxt = (state == PUBLISH) ? 4'h0 : seen;
    if (cap_acc)
      seen_nxt[cap_idx] = 1'b1;
    state_nxt = state;
    if (state == COLLECT) begin
      if (seen_nxt == 4'hF)
        state_nxt = PUBLISH;
    end else begin
      state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen  <= 4'h0;
      state <= COLLECT;
    end else begin
      seen  <= seen_nxt;
      state <= state_nxt;
    end
  end

  // Stage p2: published frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'h0000;
      dp          <= 4'h0;
      err         <= 4'h0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (state == PUBLISH);
      if (state == PUBLISH) begin
        digits    <= shadow_val;
        dp        <= shadow_dp;
        err       <= shadow_err;
        frame_err <= |shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed scans plus random traffic against a
// run-length based behavioural model of digit capture and frame publishing.
module tb_sseg_scan_decoder;

  localparam int S = 16;
  localparam logic [7:0] TBL [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                      8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sseg_in = 8'h00;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp, err;
  logic        frame_err, frame_valid;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;
  time fv_times[$];

  // Model state: a published frame, a shadow frame, and the current input run.
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_err, seen;
  logic        m_ferr, m_fv;
  logic [3:0]  sh_val [4];
  logic [3:0]  sh_dp, sh_err;
  bit          pend;
  logic [3:0]  cur_an;
  logic [7:0]  cur_ss;
  int          run;

  sseg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .an_in(an_in),
    .digits(digits), .dp(dp), .err(err),
    .frame_err(frame_err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_decode(input logic [7:0] s);
    for (int k = 0; k < 10; k++)
      if ({s[7:1], 1'b0} == TBL[k]) return {1'b0, 4'(k)};
    return 5'h1F;
  endfunction

  function automatic void model_reset();
    m_digits = 16'h0; m_dp = 4'h0; m_err = 4'h0; m_ferr = 1'b0; m_fv = 1'b0;
    for (int i = 0; i < 4; i++) sh_val[i] = 4'h0;
    sh_dp = 4'h0; sh_err = 4'h0; seen = 4'h0; pend = 1'b0;
    cur_an = 4'hF; cur_ss = 8'h00; run = 2;
  endfunction

  // A digit is captured once its registered value has been seen S+1 times in a row.
  function automatic void model_clock();
    logic [4:0] d;
    int idx;
    bit cap;
    cap = (run == S + 1) && ($countones(~cur_an) == 1);
    if (pend) begin
      m_digits = {sh_val[3], sh_val[2], sh_val[1], sh_val[0]};
      m_dp = sh_dp; m_err = sh_err; m_ferr = |sh_err; m_fv = 1'b1;
      seen = 4'h0; pend = 1'b0;
    end else begin
      m_fv = 1'b0;
    end
    if (cap) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!cur_an[i]) idx = i;
      d = ref_decode(cur_ss);
      sh_val[idx] = d[3:0]; sh_dp[idx] = cur_ss[0]; sh_err[idx] = d[4];
      seen[idx] = 1'b1;
    end
    pend = (seen == 4'hF);
    if (an_in == cur_an && sseg_in == cur_ss) begin
      if (run < 100000) run++;
    end else begin
      cur_an = an_in; cur_ss = sseg_in; run = 1;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_clock();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1) fv_times.push_back($time);
      if (chk_en) begin
        tests++;
        if ({digits, dp, err, frame_err, frame_valid} !== {m_digits, m_dp, m_err, m_ferr, m_fv}) begin
          fails++;
          $display("FAIL model_cmp t=%0t: dut digits=%h dp=%b err=%b ferr=%b fv=%b, want digits=%h dp=%b err=%b ferr=%b fv=%b",
                   $time, digits, dp, err, frame_err, frame_valid, m_digits, m_dp, m_err, m_ferr, m_fv);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an_in = a; sseg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_digits"}, 32'(digits), 32'h0);
    chk({nm, "_flags"}, {22'd0, dp, err, frame_err, frame_valid}, 32'h0);
  endtask

  int   n0;
  time  t0;
  logic [3:0] ra;
  logic [7:0] rs;

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1 chk_reset_vals("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(4'hF, 8'h00, 3);

    // Basic scan 1,2,3,4
    n0 = fv_times.size();
    hold(4'b1110, 8'h60, 20);
    hold(4'b1101, 8'hDA, 20);
    hold(4'b1011, 8'hF2, 20);
    t0 = $time;
    hold(4'b0111, 8'h66, 20);
    hold(4'hF, 8'h00, 5);
    chk("scan_fv_count", 32'(fv_times.size() - n0), 32'd1);
    chk("scan_fv_time", (fv_times.size() > n0) ? 32'(fv_times[$] - t0) : 32'hFFFF_FFFF, 32'd190);
    chk("scan_digits", 32'(digits), 32'h4321);
    chk("scan_dp_err", {23'd0, dp, err, frame_err}, 32'h0);

    // Invalid pattern and decimal point
    n0 = fv_times.size();
    hold(4'b1110, 8'h60, 20);
    hold(4'b1101, 8'hDB, 20);
    hold(4'b1011, 8'h00, 20);
    hold(4'b0111, 8'h66, 20);
    hold(4'hF, 8'h00, 5);
    chk("inv_fv_count", 32'(fv_times.size() - n0), 32'd1);
    chk("inv_digits", 32'(digits), 32'h4F21);
    chk("inv_err", 32'(err), 32'h4);
    chk("inv_frame_err", 32'(frame_err), 32'h1);
    chk("inv_dp", 32'(dp), 32'h2);

    // Glitch, blank and multi-select do not disturb collected digits
    n0 = fv_times.size();
    hold(4'b1101, 8'hF6, 20);
    hold(4'b1011, 8'hBE, 20);
    hold(4'b0111, 8'hE0, 20);
    hold(4'b1110, 8'hFE, 10);
    hold(4'hF, 8'h00, 40);
    hold(4'b1100, 8'h60, 40);
    chk("glitch_no_publish", 32'(fv_times.size() - n0), 32'd0);
    hold(4'b1110, 8'hB6, 20);
    hold(4'hF, 8'h00, 5);
    chk("glitch_fv_count", 32'(fv_times.size() - n0), 32'd1);
    chk("glitch_digits", 32'(digits), 32'h7695);

    // Back-to-back frames, 17 cycles per digit
    n0 = fv_times.size();
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 4; i++) begin
        ra = 4'hF; ra[i] = 1'b0;
        hold(ra, TBL[(f + i) % 10], 17);
      end
    hold(4'hF, 8'h00, 5);
    chk("b2b_fv_count", 32'(fv_times.size() - n0), 32'd6);
    for (int i = n0 + 1; i < fv_times.size(); i++)
      chk("b2b_gap", 32'(fv_times[i] - fv_times[i-1]), 32'd680);
    chk("b2b_digits", 32'(digits), 32'h8765);

    // Asynchronous reset mid-frame discards collected digits
    hold(4'b1110, 8'h60, 20);
    hold(4'b1101, 8'hDA, 20);
    hold(4'b1011, 8'hF2, 20);
    #3 rst = 1'b1;
    #1 chk_reset_vals("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n0 = fv_times.size();
    hold(4'b0111, 8'h66, 40);
    hold(4'hF, 8'h00, 5);
    hold(4'b1110, 8'h60, 20);
    hold(4'b1101, 8'hDA, 20);
    chk("rstmid_no_publish", 32'(fv_times.size() - n0), 32'd0);
    hold(4'b1011, 8'hF2, 20);
    hold(4'hF, 8'h00, 5);
    chk("rstmid_fv_count", 32'(fv_times.size() - n0), 32'd1);
    chk("rstmid_digits", 32'(digits), 32'h4321);

    // Random traffic
    n0 = fv_times.size();
    for (int e = 0; e < 400; e++) begin
      case ($urandom_range(0, 9))
        8:       ra = 4'hF;
        9:       ra = 4'($urandom);
        default: begin ra = 4'hF; ra[$urandom_range(0, 3)] = 1'b0; end
      endcase
      if ($urandom_range(0, 3) != 0)
        rs = TBL[$urandom_range(0, 9)] | 8'($urandom_range(0, 1));
      else
        rs = 8'($urandom);
      hold(ra, rs, $urandom_range(1, 40));
    end
    hold(4'hF, 8'h00, 5);
    chk("random_published", (fv_times.size() > n0) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
